// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8-bit asynchronous serial receiver (8N1, or 8E1 when
//            UART_RX_PARITY_EN is defined) with a one-entry valid/ready
//            holding register and one-cycle error pulses.
// Ports    : clk          - single clock, all logic on rising edge
//            rst          - synchronous active-high reset
//            rx           - serial line, asynchronous, idle high
//            rx_data[7:0] - received byte, valid while rx_valid=1
//            rx_valid     - byte held for the consumer
//            rx_ready     - consumer accept (transfer = rx_valid & rx_ready)
//            frame_error  - one-cycle pulse, stop bit sampled low
//            overrun      - one-cycle pulse, byte dropped (holding reg full)
//            parity_error - one-cycle pulse, even-parity mismatch
//                           (constant 0 without UART_RX_PARITY_EN)
// Macro    : UART_RX_PARITY_EN - adds one even-parity bit between DATA
//            and STOP.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam int c_divisor = CLK_FREQ / BAUD_RATE;
    localparam int c_baud_w  = (c_divisor > 1) ? $clog2(c_divisor) : 1;
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(c_divisor - 1);
    // Start bit is checked half a bit period after the falling edge so
    // every later sample lands near the middle of its bit.
    localparam logic [c_baud_w-1:0] c_baud_half = c_baud_w'(c_divisor / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_hist;
    state_t              r_state;
    state_t              w_state_next;
    logic [c_baud_w-1:0] r_baud;
    logic [c_baud_w-1:0] w_baud_next;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                w_tick;
    logic                w_stop_ok;
    logic                w_stop_bad;
    logic                w_par_bad;
    logic                w_load;
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_frame_err;
    logic                r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                r_par_bad;
    logic                w_par_bad_next;
    logic                r_par_err;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_tick = (r_baud == c_baud_last);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_cnt <= w_bit_next;
            r_shift   <= w_shift_next;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_next = r_par_bad;
`endif
        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                w_bit_next  = '0;
`ifdef UART_RX_PARITY_EN
                w_par_bad_next = 1'b0;
`endif
                // Only a high-to-low transition starts a frame, so a line
                // stuck low cannot retrigger.
                if (r_hist && !r_sync2) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_baud == c_baud_half) begin
                    w_baud_next  = '0;
                    w_state_next = r_sync2 ? IDLE : DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            DATA: begin
                w_baud_next = w_tick ? '0 : r_baud + 1'b1;
                if (w_tick) begin
                    w_shift_next = {r_sync2, r_shift[7:1]};
                    w_bit_next   = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                w_baud_next = w_tick ? '0 : r_baud + 1'b1;
                if (w_tick) begin
                    // Even parity: data bits plus parity bit hold an even
                    // number of ones.
                    w_par_bad_next = (r_sync2 != ^r_shift);
                    w_state_next   = STOP;
                end
            end
`endif
            STOP: begin
                w_baud_next = w_tick ? '0 : r_baud + 1'b1;
                if (w_tick) begin
                    w_state_next = IDLE;
                    w_stop_ok    = r_sync2;
                    w_stop_bad   = !r_sync2;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    // A good frame is only delivered when stop and parity are both clean;
    // a bad stop bit suppresses every other indication.
    assign w_load = w_stop_ok && !w_par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_load && r_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= w_stop_ok && r_par_bad;
`endif
            // A transfer in the same cycle frees the slot for the new byte.
            if (w_load && (!r_valid || rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_error = r_frame_err;
    assign overrun     = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_error = r_par_err;
`else
    assign parity_error = 1'b0;
`endif

endmodule
`default_nettype wire
